// File: rtl/axi_arb_pkg.sv
// Shared state encoding, AXI constants and size helper for the AXI master arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [2:0] size_log2(input int data_w);
    logic [2:0] r;
    r = 3'd0;
    for (int b = 0; b < 8; b++)
      if ((8 << b) == data_w) r = 3'(b);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request picker: round-robin starting at ptr, or lowest-index-wins when
// AXI_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] j;
  logic             found;

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start = ptr;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = IDX_W'((int'(start) + k) % N);
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        idx      = j;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port among NUM_REQ single-beat requesters, one transaction at a time.
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ID_W-1:0]       M_AWID,
  output logic [ADDR_W-1:0]     M_AWADDR,
  output logic [7:0]            M_AWLEN,
  output logic [2:0]            M_AWSIZE,
  output logic [1:0]            M_AWBURST,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_W-1:0]     M_WDATA,
  output logic [DATA_W/8-1:0]   M_WSTRB,
  output logic                  M_WLAST,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [ID_W-1:0]       M_BID,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ID_W-1:0]       M_ARID,
  output logic [ADDR_W-1:0]     M_ARADDR,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [ID_W-1:0]       M_RID,
  input  logic [DATA_W-1:0]     M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_next, gidx, arb_idx;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               aw_done, w_done;
  logic [ID_W-1:0]    gid;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign gid      = ID_W'(gidx);

  assign M_AWID    = gid;
  assign M_AWADDR  = addr_q;
  assign M_AWLEN   = 8'd0;
  assign M_AWSIZE  = size_log2(DATA_W);
  assign M_AWBURST = BURST_INCR;
  assign M_WDATA   = wdata_q;
  assign M_WSTRB   = '1;
  assign M_WLAST   = 1'b1;
  assign M_ARID    = gid;
  assign M_ARADDR  = addr_q;
  assign M_ARLEN   = 8'd0;
  assign M_ARSIZE  = size_log2(DATA_W);
  assign M_ARBURST = BURST_INCR;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state   <= IDLE;
      ptr     <= '0;
      gidx    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && |req_valid) begin
        gidx    <= arb_idx;
        addr_q  <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
        wdata_q <= req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
        ptr     <= ptr_next;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      // AW and W complete independently; each valid drops after its own handshake
      if (state == WRITE) begin
        aw_done <= aw_done | M_AWREADY;
        w_done  <= w_done | M_WREADY;
      end
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_resp  = RESP_OKAY;
    M_AWVALID = 1'b0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = arb_grant;
          state_n   = req_write[arb_idx] ? WRITE : RADDR;
        end
      end
      WRITE: begin
        M_AWVALID = !aw_done;
        M_WVALID  = !w_done;
        if ((aw_done || M_AWREADY) && (w_done || M_WREADY)) state_n = WRESP;
      end
      WRESP: begin
        M_BREADY = 1'b1;
        if (M_BVALID) begin
          rsp_valid[gidx] = 1'b1;
          rsp_resp        = (M_BID != gid) ? RESP_SLVERR : M_BRESP;
          state_n         = IDLE;
        end
      end
      RADDR: begin
        M_ARVALID = 1'b1;
        if (M_ARREADY) state_n = RDATA;
      end
      RDATA: begin
        M_RREADY = 1'b1;
        // non-last beats are consumed and dropped
        if (M_RVALID && M_RLAST) begin
          rsp_valid[gidx] = 1'b1;
          rsp_rdata       = M_RDATA;
          rsp_resp        = (M_RID != gid) ? RESP_SLVERR : M_RRESP;
          state_n         = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Self-checking bench for axi_master_arbiter: directed scenarios plus randomized
// traffic against a grant-order and memory reference model.
module tb_axi_master_arbiter;
  localparam int N = 4, AW = 32, DW = 64, IW = 4;

  logic ACLK = 1'b0;
  logic ARESETn;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [IW-1:0]   M_AWID, M_ARID, M_BID, M_RID;
  logic [AW-1:0]   M_AWADDR, M_ARADDR;
  logic [7:0]      M_AWLEN, M_ARLEN;
  logic [2:0]      M_AWSIZE, M_ARSIZE;
  logic [1:0]      M_AWBURST, M_ARBURST, M_BRESP, M_RRESP;
  logic            M_AWVALID, M_AWREADY, M_WLAST, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic            M_ARVALID, M_ARREADY, M_RLAST, M_RVALID, M_RREADY;
  logic [DW-1:0]   M_WDATA, M_RDATA;
  logic [DW/8-1:0] M_WSTRB;

  int tests_run = 0;
  int tests_failed = 0;
  int ptr_model = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];

  typedef struct {
    int idx; logic wr; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [IW-1:0] id;
    logic [N-1:0] rsp_vec; logic [DW-1:0] rsp_rd; logic [1:0] rsp_rs;
    int aw_cnt; int w_cnt; bit early; bit glitch; bit ok;
  } obs_t;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE),
    .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
    .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  // Expected winner from the arbitration rule, independent of the RTL structure.
  function automatic int exp_winner(input logic [N-1:0] v, input int p);
    int c;
`ifdef AXI_ARB_FIXED_PRIO_EN
    c = 0 * p;
`else
    c = p;
`endif
    for (int k = 0; k < N; k++) if (v[(c + k) % N]) return (c + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    ptr_model = 0;
  endtask

  // Acts as requester handshake plus AXI slave for one transaction; returns observations.
  task automatic serve(input int aw_lat, input int w_lat, input int ar_lat, input int rsp_lat,
                       input int extra, input logic [IW-1:0] id_xor, input logic [1:0] code,
                       input logic [DW-1:0] rd_data, output obs_t o);
    int t;
    bit aw_hs, w_hs;
    o.idx = -1; o.wr = 0; o.addr = '0; o.wdata = '0; o.id = '0; o.rsp_vec = '0;
    o.rsp_rd = '0; o.rsp_rs = '0; o.aw_cnt = 0; o.w_cnt = 0; o.early = 0; o.glitch = 0; o.ok = 0;
    for (t = 0; t < 40; t++) begin
      #1;
      if (|req_ready) break;
      @(negedge ACLK);
    end
    if (t == 40) return;
    for (int i = 0; i < N; i++) if (req_ready[i]) o.idx = i;
    @(negedge ACLK);
    req_valid[o.idx] = 1'b0;
    #1;
    o.wr = M_AWVALID;
    if (!M_AWVALID && !M_ARVALID) return;
    if (o.wr) begin
      aw_hs = 0; w_hs = 0;
      for (t = 0; t < 50 && !(aw_hs && w_hs); t++) begin
        if (M_BREADY) o.early = 1;
        if (M_AWVALID) o.aw_cnt++;
        if (M_WVALID) o.w_cnt++;
        M_AWREADY = (t >= aw_lat);
        M_WREADY = (t >= w_lat);
        if (M_AWVALID && M_AWREADY) begin aw_hs = 1; o.addr = M_AWADDR; o.id = M_AWID; end
        if (M_WVALID && M_WREADY) begin w_hs = 1; o.wdata = M_WDATA; end
        @(negedge ACLK); #1;
      end
      M_AWREADY = 0; M_WREADY = 0;
      if (!(aw_hs && w_hs)) return;
      for (t = 0; t < rsp_lat; t++) begin @(negedge ACLK); #1; end
      for (t = 0; t < 50 && !M_BREADY; t++) begin @(negedge ACLK); #1; end
      if (!M_BREADY) return;
      M_BVALID = 1; M_BID = o.id ^ id_xor; M_BRESP = code;
      #1;
      o.rsp_vec = rsp_valid; o.rsp_rs = rsp_resp; o.rsp_rd = rsp_rdata;
      @(negedge ACLK);
      M_BVALID = 0;
      #1;
    end else begin
      for (t = 0; t < 50; t++) begin
        M_ARREADY = (t >= ar_lat);
        if (M_ARVALID && M_ARREADY) break;
        @(negedge ACLK); #1;
      end
      if (t == 50) begin M_ARREADY = 0; return; end
      o.addr = M_ARADDR; o.id = M_ARID;
      @(negedge ACLK);
      M_ARREADY = 0;
      #1;
      for (t = 0; t < rsp_lat; t++) begin @(negedge ACLK); #1; end
      for (t = 0; t < 50 && !M_RREADY; t++) begin @(negedge ACLK); #1; end
      if (!M_RREADY) return;
      for (int b = 0; b < extra; b++) begin
        M_RVALID = 1; M_RLAST = 0; M_RID = o.id; M_RDATA = {$urandom, $urandom}; M_RRESP = 2'b00;
        #1;
        if (|rsp_valid) o.glitch = 1;
        @(negedge ACLK); #1;
      end
      M_RVALID = 1; M_RLAST = 1; M_RID = o.id ^ id_xor; M_RDATA = rd_data; M_RRESP = code;
      #1;
      o.rsp_vec = rsp_valid; o.rsp_rs = rsp_resp; o.rsp_rd = rsp_rdata;
      @(negedge ACLK);
      M_RVALID = 0; M_RLAST = 0;
      #1;
    end
    o.ok = 1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    tests_run++; if ({req_ready, rsp_valid} !== '0) begin tests_failed++; $display("FAIL reset_handshake: got %b expected 0", {req_ready, rsp_valid}); end
    tests_run++; if ({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY} !== 5'b0) begin tests_failed++; $display("FAIL reset_axi_valids: got %b expected 00000", {M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}); end
    tests_run++; if ({rsp_rdata, rsp_resp} !== '0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h/%b expected 0", rsp_rdata, rsp_resp); end
    tests_run++; if ({M_AWLEN, M_AWSIZE, M_AWBURST, M_WSTRB, M_WLAST, M_ARLEN, M_ARSIZE, M_ARBURST} !== {8'd0, 3'd3, 2'b01, 8'hFF, 1'b1, 8'd0, 3'd3, 2'b01}) begin tests_failed++; $display("FAIL const_fields: AWLEN %0d AWSIZE %0d AWBURST %b WSTRB %h WLAST %b expected 0/3/01/ff/1", M_AWLEN, M_AWSIZE, M_AWBURST, M_WSTRB, M_WLAST); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    ptr_model = 0;
  endtask

  task automatic test_stray_beats();
    @(negedge ACLK);
    M_BVALID = 1; M_BID = 0; M_RVALID = 1; M_RLAST = 1; M_RID = 0;
    repeat (2) begin
      #1;
      tests_run++; if ({M_BREADY, M_RREADY, rsp_valid} !== '0) begin tests_failed++; $display("FAIL stray_beats: bready/rready/rsp got %b expected 0", {M_BREADY, M_RREADY, rsp_valid}); end
      @(negedge ACLK);
    end
    M_BVALID = 0; M_RVALID = 0; M_RLAST = 0;
  endtask

  task automatic test_write_read();
    obs_t o;
    @(negedge ACLK);
    set_req(0, 1'b1, 32'h1000, 64'hFACECAFEDEADBEEF);
    serve(0, 0, 0, 0, 0, '0, 2'b00, '0, o);
    tests_run++; if (o.ok !== 1'b1) begin tests_failed++; $display("FAIL wr_complete: timed out, got ok=%0d expected 1", o.ok); end
    tests_run++; if ({o.wr, o.addr, o.id} !== {1'b1, 32'h1000, 4'd0}) begin tests_failed++; $display("FAIL wr_aw: wr %b addr %h id %0d expected 1/1000/0", o.wr, o.addr, o.id); end
    tests_run++; if (o.wdata !== 64'hFACECAFEDEADBEEF) begin tests_failed++; $display("FAIL wr_wdata: got %h expected facecafedeadbeef", o.wdata); end
    tests_run++; if ({o.rsp_vec, o.rsp_rs} !== {4'b0001, 2'b00}) begin tests_failed++; $display("FAIL wr_rsp: got %b/%b expected 0001/00", o.rsp_vec, o.rsp_rs); end
    mem[32'h1000] = 64'hFACECAFEDEADBEEF;
    ptr_model = 1;
    set_req(2, 1'b0, 32'h1000, '0);
    serve(0, 0, 1, 1, 0, '0, 2'b00, mem[32'h1000], o);
    tests_run++; if ({o.ok, o.wr, o.addr, o.id} !== {1'b1, 1'b0, 32'h1000, 4'd2}) begin tests_failed++; $display("FAIL rd_ar: ok %0d wr %b addr %h id %0d expected 1/0/1000/2", o.ok, o.wr, o.addr, o.id); end
    tests_run++; if ({o.rsp_vec, o.rsp_rs} !== {4'b0100, 2'b00}) begin tests_failed++; $display("FAIL rd_rsp: got %b/%b expected 0100/00", o.rsp_vec, o.rsp_rs); end
    tests_run++; if (o.rsp_rd !== 64'hFACECAFEDEADBEEF) begin tests_failed++; $display("FAIL rd_data: got %h expected facecafedeadbeef", o.rsp_rd); end
    ptr_model = 3;
  endtask

  task automatic test_grant_order();
    obs_t o;
    int e;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h100 * (i + 1), '0);
    for (int n = 0; n < 8; n++) begin
      req_valid = '1;
      e = exp_winner(req_valid, ptr_model);
      serve(0, 0, $urandom_range(0, 2), 0, 0, '0, 2'b00, 64'(n), o);
      tests_run++; if (o.idx !== e || o.rsp_vec !== 4'(1 << e)) begin tests_failed++; $display("FAIL grant_order[%0d]: granted %0d rsp %b expected %0d", n, o.idx, o.rsp_vec, e); end
      ptr_model = (e + 1) % N;
    end
    req_valid = '0;
  endtask

  task automatic test_aw_stall();
    obs_t o;
    @(negedge ACLK);
    set_req(1, 1'b1, 32'h2040, 64'h0123456789ABCDEF);
    serve(5, 0, 0, 0, 0, '0, 2'b00, '0, o);
    tests_run++; if ({o.ok, o.w_cnt, o.aw_cnt} !== {1'b1, 32'd1, 32'd6}) begin tests_failed++; $display("FAIL aw_stall_valids: ok %0d wvalid cycles %0d awvalid cycles %0d expected 1/1/6", o.ok, o.w_cnt, o.aw_cnt); end
    tests_run++; if (o.early !== 1'b0) begin tests_failed++; $display("FAIL aw_stall_bready: bready before both done got %0d expected 0", o.early); end
    tests_run++; if ({o.rsp_vec, o.wdata} !== {4'b0010, 64'h0123456789ABCDEF}) begin tests_failed++; $display("FAIL aw_stall_rsp: got %b/%h expected 0010/0123456789abcdef", o.rsp_vec, o.wdata); end
    mem[32'h2040] = 64'h0123456789ABCDEF;
    ptr_model = 2;
  endtask

  task automatic test_id_mismatch();
    obs_t o;
    @(negedge ACLK);
    set_req(1, 1'b1, 32'h3000, 64'h55);
    serve(0, 0, 0, 0, 0, 4'd2, 2'b00, '0, o);
    tests_run++; if ({o.id, o.rsp_vec, o.rsp_rs} !== {4'd1, 4'b0010, 2'b10}) begin tests_failed++; $display("FAIL bid_mismatch: id %0d rsp %b resp %b expected 1/0010/10", o.id, o.rsp_vec, o.rsp_rs); end
    mem[32'h3000] = 64'h55;
    set_req(0, 1'b0, 32'h3000, '0);
    serve(0, 0, 0, 0, 1, 4'd1, 2'b00, 64'h77, o);
    tests_run++; if ({o.rsp_vec, o.rsp_rs, o.glitch} !== {4'b0001, 2'b10, 1'b0}) begin tests_failed++; $display("FAIL rid_mismatch: rsp %b resp %b early %0d expected 0001/10/0", o.rsp_vec, o.rsp_rs, o.glitch); end
    ptr_model = 1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int t;
    @(negedge ACLK);
    set_req(1, 1'b0, 32'h4000, '0);
    for (t = 0; t < 20; t++) begin #1; if (req_ready[1]) break; @(negedge ACLK); end
    tests_run++; if (t == 20) begin tests_failed++; $display("FAIL midrst_grant: req_ready[1] got 0 expected 1 within 20 cycles"); end
    @(negedge ACLK);
    req_valid = '0;
    M_ARREADY = 1;
    @(negedge ACLK);
    M_ARREADY = 0;
    #1;
    tests_run++; if (M_RREADY !== 1'b1) begin tests_failed++; $display("FAIL midrst_rready_before: got %b expected 1", M_RREADY); end
    ARESETn = 0; M_RVALID = 1; M_RLAST = 1; M_RID = 4'd1; M_RDATA = 64'h99;
    #1;
    tests_run++; if ({M_RREADY, rsp_valid} !== 5'b0) begin tests_failed++; $display("FAIL midrst_outputs: rready/rsp got %b expected 00000", {M_RREADY, rsp_valid}); end
    @(negedge ACLK);
    M_RVALID = 0; M_RLAST = 0;
    @(negedge ACLK);
    ARESETn = 1;
    ptr_model = 0;
    set_req(1, 1'b0, 32'h4008, '0);
    serve(0, 0, 0, 0, 0, '0, 2'b01, 64'hABCD, o);
    tests_run++; if ({o.ok, o.id, o.rsp_vec, o.rsp_rs, o.rsp_rd} !== {1'b1, 4'd1, 4'b0010, 2'b01, 64'hABCD}) begin tests_failed++; $display("FAIL midrst_after: ok %0d id %0d rsp %b resp %b data %h expected 1/1/0010/01/abcd", o.ok, o.id, o.rsp_vec, o.rsp_rs, o.rsp_rd); end
    ptr_model = 2;
  endtask

  task automatic test_random();
    obs_t o;
    logic [N-1:0] mask;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic w [N];
    logic [DW-1:0] rd;
    logic [IW-1:0] idx_x;
    logic [1:0] code, exp_rs;
    int e;
    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      req_valid = '0;
      for (int i = 0; i < N; i++) begin
        w[i] = 1'($urandom);
        a[i] = 32'h5000 + 32'(8 * $urandom_range(0, 5));
        d[i] = {$urandom, $urandom};
        if (mask[i]) set_req(i, w[i], a[i], d[i]);
      end
      e = exp_winner(mask, ptr_model);
      idx_x = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      code = 2'($urandom);
      exp_rs = (idx_x != 0) ? 2'b10 : code;
      rd = mem.exists(a[e]) ? mem[a[e]] : {$urandom, $urandom};
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 2), idx_x, code, rd, o);
      tests_run++;
      if (!o.ok || o.idx !== e || o.wr !== w[e] || o.addr !== a[e] || o.id !== 4'(e) ||
          o.rsp_vec !== 4'(1 << e) || o.rsp_rs !== exp_rs || o.glitch ||
          (w[e] && o.wdata !== d[e]) || (!w[e] && o.rsp_rd !== rd)) begin
        tests_failed++;
        $display("FAIL random[%0d]: ok %0d idx %0d wr %b addr %h id %0d rsp %b resp %b wdata %h rdata %h | expected idx %0d wr %b addr %h rsp %b resp %b wdata %h rdata %h",
                 n, o.ok, o.idx, o.wr, o.addr, o.id, o.rsp_vec, o.rsp_rs, o.wdata, o.rsp_rd,
                 e, w[e], a[e], 4'(1 << e), exp_rs, d[e], rd);
      end
      if (w[e]) mem[a[e]] = d[e];
      ptr_model = (e + 1) % N;
      req_valid = '0;
    end
  endtask

  initial begin
    ARESETn = 0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BID = '0; M_BRESP = '0; M_BVALID = 0;
    M_ARREADY = 0; M_RID = '0; M_RDATA = '0; M_RRESP = '0; M_RLAST = 0; M_RVALID = 0;
    test_reset();
    test_stray_beats();
    test_write_read();
    test_grant_order();
    test_aw_stall();
    test_id_mismatch();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge ACLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
